rom_read_controller: RTL
========================

# rom_read_controller

Sequences reads of the parallel ROM under test: steps the 9-bit address bus over a requested range, drives chip-select/output-enable with programmable setup and access times, captures each data word and hands it downstream over a valid/ready handshake. Sits between the ROM socket pins and the capture/transfer logic. Its `rom_address` output also feeds the decimal address display.

## Interface
- `ADDR_WIDTH`, 9, ROM address width.
- `DATA_WIDTH`, 8, ROM data width.
- `SETUP_CYCLES`, 1, cycles of address+CS before OE asserts; legal range ≥1.
- `ACCESS_CYCLES`, 4, cycles OE is held before data is sampled; legal range ≥1.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin a scan; sampled only in IDLE.
- `abort` in 1: terminate the scan; sampled in any non-IDLE state.
- `start_address` in ADDR_WIDTH: first address; latched on accepted `start`.
- `end_address` in ADDR_WIDTH: last address, inclusive; latched on accepted `start`.
- `rom_data` in DATA_WIDTH: ROM data pins.
- `rom_address` out ADDR_WIDTH: ROM address pins.
- `rom_cs_n` out 1: chip select, active-low.
- `rom_oe_n` out 1: output enable, active-low.
- `data_out` out DATA_WIDTH: captured word.
- `data_valid` out 1: `data_out` holds a word for `rom_address`.
- `data_ready` in 1: consumer accepts the word.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the last word has been accepted.

## Operation
- Reset values: `rom_address`=0, `rom_cs_n`=1, `rom_oe_n`=1, `data_out`=0, `data_valid`=0, `busy`=0, `done`=0, state IDLE.
- IDLE: CS/OE deasserted. On `start`=1, latch both addresses, set `rom_address`=`start_address`, load timer, go to SETUP.
- SETUP: `rom_cs_n`=0, `rom_oe_n`=1 for SETUP_CYCLES cycles, then go to ACCESS.
- ACCESS: `rom_cs_n`=0, `rom_oe_n`=0 for ACCESS_CYCLES cycles. On the edge that ends the last cycle, register `rom_data` into `data_out` and go to HANDOFF.
- HANDOFF: `data_valid`=1, `rom_cs_n`=`rom_oe_n`=1, `data_out` and `rom_address` stable.
  - On `data_valid & data_ready`, if `rom_address`==latched end, go to DONE.
  - Otherwise `rom_address`+1 and go to SETUP.
- DONE: `done`=1 for one cycle, then IDLE. `rom_address` keeps the last address.
- `end_address` < `start_address`: only `start_address` is read, then DONE. The address never wraps; the increment is ADDR_WIDTH bits and is never applied past end.
- `abort` has priority over `data_ready` and timer expiry. The next state is IDLE, `data_valid` drops, CS/OE deassert, `done` is not pulsed, `rom_address` holds.
- `start` while `busy` is ignored. `start` and `abort` together in IDLE: the scan starts (`abort` is ignored in IDLE).
- Reset asserted mid-scan: all outputs return immediately (asynchronously) to reset values.

## Timing
- Accepted `start` at edge 0:
  - SETUP occupies cycles 1..S.
  - ACCESS occupies cycles S+1..S+A.
  - `data_valid` is high from cycle S+A+1.
- Minimum word period with `data_ready` held high is S+A+1 cycles. Defaults give 6 cycles per word, so a full 0..511 scan takes 3072 cycles plus 1 DONE cycle.
- `data_out` is sampled after ≥A cycles of OE low. `rom_address` never changes while `rom_cs_n`=0.
- The handshake follows the AXI-style rule: once `data_valid` rises it stays high, with stable data, until accepted or aborted.
- Back-pressure is unbounded: HANDOFF holds indefinitely.

## Structure
- Shared package `rom_reader_pkg` holds:
  - the state enumeration (IDLE, SETUP, ACCESS, HANDOFF, DONE);
  - default ADDR_WIDTH/DATA_WIDTH;
  - the timer width function clog2(max(S,A)+1).
- One sub-module, `cycle_timer`: a loadable down-counter with a `load` value and an `expired` flag, shared by SETUP and ACCESS.

## Test plan
- Range 0..3, defaults, `data_ready`=1, ROM model returns ~addr → words 0xFF,0xFE,0xFD,0xFC at 6-cycle spacing, `done` pulse 1 cycle after the 4th acceptance.
- Range 10..12, `data_ready` low for 20 cycles each word → `data_valid` and `data_out` stay stable while held, CS/OE high during the hold, exactly 3 transfers.
- `abort` in ACCESS of address 5 → IDLE next cycle, no `done`, `data_valid` never asserted for 5, `rom_address`=5.
- `start_address`=511, `end_address`=511; then separately 20..7 → each case reads a single word, no wrap to 0.
- Reset pulsed low mid-HANDOFF → outputs are at reset values immediately. A new `start` after release works, and `start` asserted while `busy` is ignored.
- S=3, A=7 → `rom_oe_n` is low for exactly 7 cycles and only after 3 CS-only cycles, with `data_valid` at cycle 11.

Source files
------------

// File: rtl/rom_reader_pkg.sv
// -----------------------------------------------------------------------------
// rom_reader_pkg
// Shared definitions for the ROM read controller:
//   - default ROM address/data widths
//   - controller state enumeration
//   - timer_width(): counter width able to hold max(setup, access) cycles
// -----------------------------------------------------------------------------
package rom_reader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 9;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_HANDOFF = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Width of a down-counter that must hold the larger of the two phase lengths.
  function automatic int timer_width(input int setup_cycles, input int access_cycles);
    int max_cycles;
    max_cycles = (setup_cycles > access_cycles) ? setup_cycles : access_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter that times the SETUP and ACCESS phases.
// Loading N makes o_expired true during the N-th cycle after the load edge,
// so the owning state can leave on exactly that edge.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_load       : load i_load_value on this edge (takes priority over counting)
//   i_load_value : phase length in cycles (>= 1)
//   o_expired    : current cycle is the last cycle of the loaded phase
// -----------------------------------------------------------------------------
module cycle_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  // Count of 1 marks the final cycle; 0 (idle/unloaded) also reads as expired.
  assign o_expired = (r_count <= WIDTH'(1));

endmodule

// File: rtl/rom_read_controller.sv
// -----------------------------------------------------------------------------
// rom_read_controller
// Scans a parallel ROM from start_address to end_address (inclusive), driving
// CS/OE with programmable setup/access times and handing each captured word
// downstream over a valid/ready handshake.
//   clk, reset          : clock; asynchronous active-low reset
//   start               : begin a scan (IDLE only); latches both addresses
//   abort               : end the scan immediately (any non-IDLE state)
//   start_address       : first address
//   end_address         : last address, inclusive
//   rom_data            : ROM data pins
//   rom_address         : ROM address pins (also feeds the address display)
//   rom_cs_n, rom_oe_n  : active-low chip select / output enable
//   data_out/data_valid : captured word and its valid flag
//   data_ready          : consumer accepts the word
//   busy                : high outside IDLE
//   done                : one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module rom_read_controller
  import rom_reader_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH-1:0] end_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_cs_n,
  output logic                  rom_oe_n,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int TIMER_W = timer_width(SETUP_CYCLES, ACCESS_CYCLES);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_rom_address;
  logic [ADDR_WIDTH-1:0] r_end_address;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  w_timer_load;
  logic [TIMER_W-1:0]    w_timer_value;
  logic                  w_timer_expired;
  logic                  w_last_word;

  // ">=" rather than "==" so a reversed range reads only the start word and
  // the address can never step past end (and therefore never wraps).
  assign w_last_word = (r_rom_address >= r_end_address);

  cycle_timer #(
    .WIDTH(TIMER_W)
  ) u_cycle_timer (
    .clk         (clk),
    .rst_n       (reset),
    .i_load      (w_timer_load),
    .i_load_value(w_timer_value),
    .o_expired   (w_timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and timer-load logic. abort is tested first in every busy
  // state so it wins over timer expiry and data_ready.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_next_state  = r_state;
    w_timer_load  = 1'b0;
    w_timer_value = TIMER_W'(SETUP_CYCLES);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_SETUP;
          w_timer_load = 1'b1;
        end
      end
      ST_SETUP: begin
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (w_timer_expired) begin
          w_next_state  = ST_ACCESS;
          w_timer_load  = 1'b1;
          w_timer_value = TIMER_W'(ACCESS_CYCLES);
        end
      end
      ST_ACCESS: begin
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (w_timer_expired) begin
          w_next_state = ST_HANDOFF;
        end
      end
      ST_HANDOFF: begin
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (data_ready) begin
          if (w_last_word) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_SETUP;
            w_timer_load = 1'b1;
          end
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Address and data registers. Address only moves in IDLE (load) or on the
  // HANDOFF->SETUP edge, both with CS deasserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rom_address <= '0;
      r_end_address <= '0;
      r_data_out    <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_rom_address <= start_address;
        r_end_address <= end_address;
      end else if (r_state == ST_HANDOFF && w_next_state == ST_SETUP) begin
        r_rom_address <= r_rom_address + ADDR_WIDTH'(1);
      end
      if (r_state == ST_ACCESS && w_next_state == ST_HANDOFF) begin
        r_data_out <= rom_data;
      end
    end
  end

  // Outputs decoded from state only, so an asynchronous reset returns them to
  // their idle values immediately.
  always_comb begin
    rom_cs_n   = 1'b1;
    rom_oe_n   = 1'b1;
    data_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      ST_IDLE:    busy       = 1'b0;
      ST_SETUP:   rom_cs_n   = 1'b0;
      ST_ACCESS: begin
        rom_cs_n = 1'b0;
        rom_oe_n = 1'b0;
      end
      ST_HANDOFF: data_valid = 1'b1;
      ST_DONE:    done       = 1'b1;
      default:    busy       = 1'b0;
    endcase
  end

  assign rom_address = r_rom_address;
  assign data_out    = r_data_out;

endmodule
